// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter slave. bclk and lrclk come from an external
// master and are sampled in the clk domain. Two 24-bit holding registers
// (left/right) feed a shared shifter that drives sdo MSB first, one bclk
// after each lrclk transition.
// Build option: define I2S_TX_UNDERRUN_ZERO_EN to send 24'h000000 on an
// underrun load. Without it the stale register contents are resent.
`timescale 1ns/100ps

module i2s_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        bclk,
  input  logic        lrclk,
  output logic        sdo,
  input  logic [23:0] dac_data,
  input  logic        dac_valid_l,
  input  logic        dac_valid_r,
  output logic        dac_req_l,
  output logic        dac_req_r,
  output logic        underrun
);

  // IDLE: no reference lrclk capture yet; LISTEN: watching for a change;
  // ARMED: change seen, load on the next bclk falling edge.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LISTEN = 2'd1,
    ST_ARMED  = 2'd2
  } state_t;

  state_t      st_reg;
  logic [2:0]  bclk_pipe_reg;
  logic [2:0]  lrclk_pipe_reg;
  logic        lr_cap_reg;
  logic        arm_ch_reg;
  logic [23:0] shift_reg;
  logic [4:0]  bit_cnt_reg;
  logic        sdo_reg;
  logic        req_l_reg;
  logic        req_r_reg;
  logic        underrun_reg;
  logic [23:0] hold_l_reg;
  logic [23:0] hold_r_reg;
  logic        fresh_l_reg;
  logic        fresh_r_reg;

  logic        bclk_rise;
  logic        bclk_fall;
  logic        lrclk_s;
  logic        load;
  logic        load_l;
  logic        load_r;
  logic [23:0] sel_word;
  logic        sel_fresh;
  logic [23:0] tx_word;

  // Stages [0],[1] form the synchronizer; [2] is the edge-detect stage.
  assign bclk_rise = bclk_pipe_reg[1] & ~bclk_pipe_reg[2];
  assign bclk_fall = ~bclk_pipe_reg[1] & bclk_pipe_reg[2];
  assign lrclk_s   = lrclk_pipe_reg[2];

  assign load   = en & (st_reg == ST_ARMED) & bclk_fall;
  assign load_l = load & ~arm_ch_reg;
  assign load_r = load & arm_ch_reg;

  assign sdo       = sdo_reg;
  assign dac_req_l = req_l_reg;
  assign dac_req_r = req_r_reg;
  assign underrun  = underrun_reg;

  // Pick the word for the channel being started; a stale register either
  // repeats or is replaced by silence depending on the build option.
  always_comb begin
    sel_word  = arm_ch_reg ? hold_r_reg : hold_l_reg;
    sel_fresh = arm_ch_reg ? fresh_r_reg : fresh_l_reg;
`ifdef I2S_TX_UNDERRUN_ZERO_EN
    tx_word   = sel_fresh ? sel_word : 24'h000000;
`else
    tx_word   = sel_word;
`endif
  end

  // Bring the external bit clock and word select into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bclk_pipe_reg  <= 3'b000;
      lrclk_pipe_reg <= 3'b000;
    end else begin
      bclk_pipe_reg  <= {bclk_pipe_reg[1:0], bclk};
      lrclk_pipe_reg <= {lrclk_pipe_reg[1:0], lrclk};
    end
  end

  // Holding registers: writes always accepted; fresh marks an unsent word.
  // A write landing in the load cycle wins, so the new word stays fresh
  // while the shifter takes the old contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_l_reg  <= 24'h000000;
      hold_r_reg  <= 24'h000000;
      fresh_l_reg <= 1'b0;
      fresh_r_reg <= 1'b0;
    end else begin
      if (dac_valid_l) hold_l_reg <= dac_data;
      if (dac_valid_r) hold_r_reg <= dac_data;
      fresh_l_reg <= dac_valid_l | (fresh_l_reg & ~load_l);
      fresh_r_reg <= dac_valid_r | (fresh_r_reg & ~load_r);
    end
  end

  // Channel-start FSM, shifter, bit counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_reg       <= ST_IDLE;
      lr_cap_reg   <= 1'b0;
      arm_ch_reg   <= 1'b0;
      shift_reg    <= 24'h000000;
      bit_cnt_reg  <= 5'd0;
      sdo_reg      <= 1'b0;
      req_l_reg    <= 1'b0;
      req_r_reg    <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      req_l_reg <= load_l;
      req_r_reg <= load_r;
      if (!en) begin
        // Idle: forget the lrclk reference so no partial word follows enable.
        st_reg       <= ST_IDLE;
        shift_reg    <= 24'h000000;
        bit_cnt_reg  <= 5'd0;
        sdo_reg      <= 1'b0;
        underrun_reg <= 1'b0;
      end else begin
        if (bclk_rise) begin
          lr_cap_reg <= lrclk_s;
          case (st_reg)
            ST_IDLE:   st_reg <= ST_LISTEN;
            ST_LISTEN: begin
              if (lrclk_s != lr_cap_reg) begin
                st_reg     <= ST_ARMED;
                arm_ch_reg <= lrclk_s;
              end
            end
            ST_ARMED:  st_reg <= ST_ARMED;
            default:   st_reg <= ST_IDLE;
          endcase
        end
        if (load) begin
          // MSB goes out on the same falling edge that loads the shifter.
          st_reg      <= ST_LISTEN;
          sdo_reg     <= tx_word[23];
          shift_reg   <= {tx_word[22:0], 1'b0};
          bit_cnt_reg <= 5'd1;
          if (!sel_fresh) underrun_reg <= 1'b1;
        end else if (bclk_fall) begin
          // Bits 1..23 follow; then zeros until the next channel start.
          sdo_reg     <= (bit_cnt_reg < 5'd24) ? shift_reg[23] : 1'b0;
          shift_reg   <= {shift_reg[22:0], 1'b0};
          bit_cnt_reg <= (bit_cnt_reg == 5'd31) ? 5'd31 : bit_cnt_reg + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: drives a 64-bclk I2S frame master, writes sample words and
// decodes sdo with an independent I2S receiver. Expected words are queued
// per channel when written and popped when the receiver completes a slot.
`timescale 1ns/100ps

module tb_i2s_tx;

  logic        clk;
  logic        rst;
  logic        en;
  logic        bclk;
  logic        lrclk;
  logic        sdo;
  logic [23:0] dac_data;
  logic        dac_valid_l;
  logic        dac_valid_r;
  logic        dac_req_l;
  logic        dac_req_r;
  logic        underrun;

  int checks = 0;
  int errors = 0;
  int bpos = 63;
  int req_l_cnt = 0;
  int req_r_cnt = 0;
  int idle_viol = 0;
  logic en_chk = 1'b0;

  logic [23:0] exp_l_q[$];
  logic [23:0] exp_r_q[$];
  logic [23:0] last_r = 24'h000000;

  int          mon_bit = 0;
  logic        mon_have = 1'b0;
  logic        mon_prev = 1'b0;
  logic        mon_ch = 1'b0;
  logic [23:0] mon_word = 24'h000000;
  logic [23:0] mon_exp = 24'h000000;

  i2s_tx dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdo         (sdo),
    .dac_data    (dac_data),
    .dac_valid_l (dac_valid_l),
    .dac_valid_r (dac_valid_r),
    .dac_req_l   (dac_req_l),
    .dac_req_r   (dac_req_r),
    .underrun    (underrun)
  );

  // 100 MHz clk with edges on half-ns points so they never meet bclk edges.
  initial begin
    clk = 1'b0;
    #0.5;
    forever #5 clk = ~clk;
  end

  // Frame master: 64 bclk per frame, lrclk changes with bclk falling edge.
  initial begin
    bclk  = 1'b1;
    lrclk = 1'b1;
    forever begin
      #81;
      bpos  = (bpos == 63) ? 0 : bpos + 1;
      lrclk = (bpos >= 32);
      bclk  = 1'b0;
      #81;
      bclk  = 1'b1;
    end
  end

  // Watchdog.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Pulse and idle activity counters, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (dac_req_l === 1'b1) req_l_cnt++;
      if (dac_req_r === 1'b1) req_r_cnt++;
      if (en_chk && (sdo !== 1'b0 || dac_req_l !== 1'b0 || dac_req_r !== 1'b0))
        idle_viol++;
    end
  end

  // I2S receiver: word starts one bclk after an lrclk change, MSB first.
  initial begin
    forever begin
      @(posedge bclk);
      if (rst !== 1'b1 || en !== 1'b1) begin
        mon_have = 1'b0;
        mon_bit  = 0;
        checks++;
        if (sdo !== 1'b0) begin
          errors++;
          $display("FAIL idle_sdo: sdo=%b required 0 at bpos %0d", sdo, bpos);
        end
      end else begin
        if (mon_bit >= 1 && mon_bit <= 24) begin
          mon_word = {mon_word[22:0], sdo};
          if (mon_bit == 24) begin
            checks++;
            if ((mon_ch == 1'b0 && exp_l_q.size() == 0) ||
                (mon_ch == 1'b1 && exp_r_q.size() == 0)) begin
              errors++;
              $display("FAIL slot_%s: got %06h with no word expected",
                       mon_ch ? "R" : "L", mon_word);
            end else begin
              mon_exp = mon_ch ? exp_r_q.pop_front() : exp_l_q.pop_front();
              if (mon_word !== mon_exp) begin
                errors++;
                $display("FAIL slot_%s: got %06h required %06h",
                         mon_ch ? "R" : "L", mon_word, mon_exp);
              end else begin
                $display("slot %s: got %06h expected %06h",
                         mon_ch ? "R" : "L", mon_word, mon_exp);
              end
            end
          end
        end else begin
          checks++;
          if (sdo !== 1'b0) begin
            errors++;
            $display("FAIL gap_sdo: sdo=%b required 0 at bpos %0d", sdo, bpos);
          end
        end
        if (mon_bit != 0 && mon_bit < 64) mon_bit++;
        if (mon_have && lrclk != mon_prev) begin
          mon_bit = 1;
          mon_ch  = lrclk;
        end
        mon_prev = lrclk;
        mon_have = 1'b1;
      end
    end
  end

  task automatic wait_bpos(input int p);
    do @(negedge bclk); while (bpos != p);
  endtask

  task automatic write_ch(input logic ch, input logic [23:0] d);
    @(posedge clk); #1;
    dac_data    = d;
    dac_valid_l = ~ch;
    dac_valid_r = ch;
    @(posedge clk); #1;
    dac_valid_l = 1'b0;
    dac_valid_r = 1'b0;
    if (ch) begin
      exp_r_q.push_back(d);
      last_r = d;
    end else begin
      exp_l_q.push_back(d);
    end
    $display("write %s %06h", ch ? "R" : "L", d);
  endtask

  task automatic write_both(input logic [23:0] d);
    @(posedge clk); #1;
    dac_data    = d;
    dac_valid_l = 1'b1;
    dac_valid_r = 1'b1;
    @(posedge clk); #1;
    dac_valid_l = 1'b0;
    dac_valid_r = 1'b0;
    exp_l_q.push_back(d);
    exp_r_q.push_back(d);
    last_r = d;
    $display("write L+R %06h", d);
  endtask

  task automatic test_reset();
    #32;
    checks++;
    if (sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b required 0", sdo); end
    checks++;
    if (dac_req_l !== 1'b0) begin errors++; $display("FAIL reset_req_l: got %b required 0", dac_req_l); end
    checks++;
    if (dac_req_r !== 1'b0) begin errors++; $display("FAIL reset_req_r: got %b required 0", dac_req_r); end
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b required 0", underrun); end
    @(negedge bclk);
    #20;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    write_ch(1'b0, 24'h123456);
    write_ch(1'b1, 24'hABCDEF);
    wait_bpos(40);
    en = 1'b1;
    wait_bpos(40);
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL basic_underrun: got %b required 0", underrun); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] d;
    for (int k = 0; k < 4; k++) begin
      req_l_cnt = 0;
      req_r_cnt = 0;
      if (k == 2) begin
        d = 24'($urandom);
        write_both(d);
      end else begin
        d = 24'($urandom);
        write_ch(1'b0, d);
        d = 24'($urandom);
        write_ch(1'b1, d);
      end
      wait_bpos(40);
      checks++;
      if (req_l_cnt != 1) begin errors++; $display("FAIL b2b_req_l: got %0d cycles required 1", req_l_cnt); end
      checks++;
      if (req_r_cnt != 1) begin errors++; $display("FAIL b2b_req_r: got %0d cycles required 1", req_r_cnt); end
      checks++;
      if (underrun !== 1'b0) begin errors++; $display("FAIL b2b_underrun: got %b required 0", underrun); end
    end
  endtask

  task automatic test_underrun();
    logic [23:0] d;
    d = 24'($urandom);
    write_ch(1'b0, d);
`ifdef I2S_TX_UNDERRUN_ZERO_EN
    exp_r_q.push_back(24'h000000);
`else
    exp_r_q.push_back(last_r);
`endif
    wait_bpos(40);
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b required 1", underrun); end
  endtask

  task automatic test_en_drop();
    wait_bpos(60);
    en = 1'b0;
    #30;
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b required 0", underrun); end
    idle_viol = 0;
    en_chk    = 1'b1;
    write_ch(1'b0, 24'h5A5A5A);
    write_ch(1'b1, 24'hC3C3C3);
    wait_bpos(10);
    wait_bpos(10);
    en_chk = 1'b0;
    checks++;
    if (idle_viol != 0) begin errors++; $display("FAIL en_low_quiet: got %0d active cycles required 0", idle_viol); end
    en = 1'b1;
    wait_bpos(40);
    write_ch(1'b1, 24'h0F1E2D);
    wait_bpos(40);
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL resume_underrun: got %b required 0", underrun); end
  endtask

  task automatic test_same_cycle();
    write_ch(1'b0, 24'h777777);
    write_ch(1'b1, 24'h246801);
    wait_bpos(1);
    @(posedge clk);
    @(posedge clk); #1;
    dac_data    = 24'h00FF00;
    dac_valid_l = 1'b1;
    @(posedge clk); #1;
    dac_valid_l = 1'b0;
    exp_l_q.push_back(24'h00FF00);
    $display("write L %06h in load cycle", 24'h00FF00);
    checks++;
    if (dac_req_l !== 1'b1) begin errors++; $display("FAIL load_cycle_req_l: got %b required 1", dac_req_l); end
    wait_bpos(40);
    write_ch(1'b1, 24'h13579B);
    wait_bpos(40);
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL same_cycle_underrun: got %b required 0", underrun); end
  endtask

  task automatic test_reset_mid_word();
    write_ch(1'b0, 24'hFFFFFF);
    write_ch(1'b1, 24'h222222);
    wait_bpos(11);
    #40;
    checks++;
    if (sdo !== 1'b1) begin errors++; $display("FAIL mid_word_sdo: got %b required 1", sdo); end
    rst = 1'b0;
    #0.2;
    checks++;
    if (sdo !== 1'b0) begin errors++; $display("FAIL async_reset_sdo: got %b required 0", sdo); end
    checks++;
    if (dac_req_l !== 1'b0 || dac_req_r !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_req: got %b%b required 00", dac_req_l, dac_req_r);
    end
    exp_l_q.delete();
    exp_r_q.delete();
    wait_bpos(19);
    #20;
    rst = 1'b1;
    write_ch(1'b0, 24'h654321);
    write_ch(1'b1, 24'h89ABCD);
    wait_bpos(30);
    wait_bpos(30);
    checks++;
    if (exp_l_q.size() != 0 || exp_r_q.size() != 0) begin
      errors++;
      $display("FAIL words_pending: got L=%0d R=%0d required 0", exp_l_q.size(), exp_r_q.size());
    end
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL final_underrun: got %b required 0", underrun); end
  endtask

  initial begin
    rst         = 1'b0;
    en          = 1'b0;
    dac_data    = 24'h000000;
    dac_valid_l = 1'b0;
    dac_valid_r = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_underrun();
    test_en_drop();
    test_same_cycle();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
